// File: rtl/pdm_capture_pkg.sv
// Shared audio constants and the capture-state encoding used by the
// PDM/PWM receive path and the other audio blocks around it.
package pdm_capture_pkg;

    // Default PCM word width of the audio path.
    localparam int AUDIO_BITDEPTH  = 12;

    // Sample window length is 2**SAMPLEFREQ_LOG2 clk cycles; 9 matches
    // the clk/512 sample_clock produced by the audio block.
    localparam int SAMPLEFREQ_LOG2 = 9;

    // SEEK waits for a framing edge, ACC integrates one window.
    typedef enum logic {
        SEEK = 1'b0,
        ACC  = 1'b1
    } capture_state_t;

endpackage

// File: rtl/pdm_capture_if.sv
// PCM sample stream: head sample plus valid/ready handshake.
// The producer uses the master view, the consumer the slave view.
interface pdm_capture_if
    import pdm_capture_pkg::*;
#(
    parameter int BITDEPTH = AUDIO_BITDEPTH
);
    logic [BITDEPTH-1:0] pcm;
    logic                pcm_valid;
    logic                pcm_ready;

    modport master (
        output pcm,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  pcm,
        input  pcm_valid,
        output pcm_ready
    );
endinterface

// File: rtl/pdm_capture_sample_fifo.sv
// Small synchronous FIFO with first-word-fall-through output: dout always
// shows the head entry. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is ignored and contents stay put.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem_reg[rd_ptr_reg[AW-1:0]];

    // Storage: cleared on reset so the head output reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer advance for accepted pushes and pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_capture.sv
// PDM/PWM capture: counts high cycles of a 1-bit stream over each
// sample_clock window, scales the count to a PCM word and queues it in a
// small FIFO behind a valid/ready handshake.
module pdm_capture
    import pdm_capture_pkg::*;
#(
    parameter int BITDEPTH   = AUDIO_BITDEPTH,
    parameter int DECIM_LOG2 = SAMPLEFREQ_LOG2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_clock,
    input  logic          pdm_in,
    pdm_capture_if.master pcm_bus,
    output logic          locked,
    output logic          overflow,
    input  logic          clear_ovf
);
    localparam int CW = DECIM_LOG2 + 1;
    localparam int SW = BITDEPTH + DECIM_LOG2 + 1;
    localparam logic [CW-1:0] WLEN  = {1'b1, {DECIM_LOG2{1'b0}}};
    localparam logic [CW-1:0] WOVER = WLEN + CW'(1);

    logic           pdm_meta_reg;
    logic           bit_s_reg;
    logic           sc_reg;
    logic           sc_prev_reg;
    logic           sc_edge;

    capture_state_t state_reg, state_next;
    logic [CW-1:0]  ones_reg, ones_next;
    logic [CW-1:0]  wcnt_reg, wcnt_next;
    logic           locked_reg, locked_next;
    logic           overflow_reg, overflow_next;
    logic           push;
    logic [CW-1:0]  ones_inc;
    logic [CW-1:0]  wcnt_inc;

    logic [SW-1:0]       ones_wide;
    logic [SW-1:0]       scaled;
    logic [BITDEPTH-1:0] sample;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic [BITDEPTH-1:0] fifo_dout;

    // Two-stage synchronizer for the stream, one stage plus history for framing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_meta_reg <= 1'b0;
            bit_s_reg    <= 1'b0;
            sc_reg       <= 1'b0;
            sc_prev_reg  <= 1'b0;
        end else begin
            pdm_meta_reg <= pdm_in;
            bit_s_reg    <= pdm_meta_reg;
            sc_reg       <= sample_clock;
            sc_prev_reg  <= sc_reg;
        end
    end

    assign sc_edge = sc_reg && !sc_prev_reg;

    // Capture state, window counters and lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= SEEK;
            ones_reg     <= '0;
            wcnt_reg     <= '0;
            locked_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ones_reg     <= ones_next;
            wcnt_reg     <= wcnt_next;
            locked_reg   <= locked_next;
            overflow_reg <= overflow_next;
        end
    end

    // Window FSM. The edge cycle always opens a fresh window, so its bit_s is
    // the first one counted; that makes a clk/512 framing yield exactly
    // 512 counted cycles and lets the first full window follow the SEEK edge.
    always_comb begin
        state_next  = state_reg;
        ones_next   = ones_reg;
        wcnt_next   = wcnt_reg;
        locked_next = locked_reg;
        push        = 1'b0;
        ones_inc    = ones_reg + CW'(bit_s_reg);
        wcnt_inc    = wcnt_reg + CW'(1);
        case (state_reg)
            SEEK: begin
                if (sc_edge) begin
                    state_next = ACC;
                    ones_next  = CW'(bit_s_reg);
                    wcnt_next  = CW'(1);
                end
            end
            ACC: begin
                if (sc_edge) begin
                    ones_next = CW'(bit_s_reg);
                    wcnt_next = CW'(1);
                    if (wcnt_reg == WLEN) begin
                        push        = 1'b1;
                        locked_next = 1'b1;
                    end else begin
                        locked_next = 1'b0;
                    end
                end else if (wcnt_inc == WOVER) begin
                    // Expected edge never came: framing lost.
                    state_next  = SEEK;
                    locked_next = 1'b0;
                    ones_next   = '0;
                    wcnt_next   = '0;
                end else begin
                    ones_next = ones_inc;
                    wcnt_next = wcnt_inc;
                end
            end
            default: begin
                state_next = SEEK;
            end
        endcase
    end

    // Count to PCM: shift into the word width, then saturate so a window that
    // is all ones maps to full scale rather than wrapping to zero.
    assign ones_wide = SW'(ones_reg);
    generate
        if (BITDEPTH >= DECIM_LOG2) begin : g_scale_up
            assign scaled = ones_wide << (BITDEPTH - DECIM_LOG2);
        end else begin : g_scale_down
            assign scaled = ones_wide >> (DECIM_LOG2 - BITDEPTH);
        end
    endgenerate
    assign sample = (|scaled[SW-1:BITDEPTH]) ? '1 : scaled[BITDEPTH-1:0];

    // Sticky overflow: a dropped sample sets it, and setting beats clearing.
    always_comb begin
        overflow_next = overflow_reg;
        if (push && fifo_full && !pop) begin
            overflow_next = 1'b1;
        end else if (clear_ovf) begin
            overflow_next = 1'b0;
        end
    end

    assign pop = !fifo_empty && pcm_bus.pcm_ready;

    sample_fifo #(
        .WIDTH (BITDEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (sample),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pcm_bus.pcm       = fifo_dout;
    assign pcm_bus.pcm_valid = !fifo_empty;
    assign locked            = locked_reg;
    assign overflow          = overflow_reg;

endmodule

// File: tb/tb_pdm_capture.sv
// Directed bench for pdm_capture: constant, toggling and duty-cycle streams,
// backpressure with overflow, short and missing framing edges, async reset.
module tb_pdm_capture;
    logic clk;
    logic rst_n;
    logic sample_clock;
    logic pdm_in;
    logic locked;
    logic overflow;
    logic clear_ovf;

    int errors = 0;
    int checks = 0;
    int mode   = 0;    // 0: const 0, 1: const 1, 2: toggle, 3: duty
    int duty_n = 0;    // ones at the start of each window in duty mode

    logic [11:0] pcm_q[$];

    pdm_capture_if #(.BITDEPTH(12)) bus ();

    pdm_capture #(
        .BITDEPTH   (12),
        .DECIM_LOG2 (9),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_clock (sample_clock),
        .pdm_in       (pdm_in),
        .pcm_bus      (bus.master),
        .locked       (locked),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every sample handed over to the consumer.
    always @(posedge clk) begin
        if (rst_n && bus.pcm_valid && bus.pcm_ready) begin
            pcm_q.push_back(bus.pcm);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs,
                               input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h..0x%0h", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < pcm_q.size()) return 32'(pcm_q[i]);
        return 32'hDEAD_BEEF;
    endfunction

    // One clk of stimulus, applied just after the rising edge.
    task automatic step(input logic sc, input int idx);
        sample_clock = sc;
        case (mode)
            0:       pdm_in = 1'b0;
            1:       pdm_in = 1'b1;
            2:       pdm_in = ~pdm_in;
            default: pdm_in = (idx < duty_n);
        endcase
        @(posedge clk);
        #1;
    endtask

    // One sample_clock period of len clks, strobe in the first clk.
    task automatic window(input int len);
        for (int i = 0; i < len; i++) begin
            step(i == 0, i);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_clock = 1'b0;
        pdm_in       = 1'b0;
        clear_ovf    = 1'b0;
        bus.pcm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pcm",       32'(bus.pcm),       32'h0);
        check("reset_valid",     32'(bus.pcm_valid), 32'h0);
        check("reset_locked",    32'(locked),        32'h0);
        check("reset_overflow",  32'(overflow),      32'h0);
        rst_n = 1'b1;

        // Constant zero: first edge is consumed by SEEK.
        mode = 0;
        bus.pcm_ready = 1'b1;
        window(512);
        check("zero_no_first",   32'(pcm_q.size()), 32'd0);
        check("zero_unlocked",   32'(locked),       32'h0);
        window(512);
        window(512);
        check("zero_count",      32'(pcm_q.size()), 32'd2);
        check("zero_s0",         q_at(0),           32'h000);
        check("zero_s1",         q_at(1),           32'h000);
        check("zero_locked",     32'(locked),       32'h1);
        $display("zero phase: samples=%0d locked=%0b", pcm_q.size(), locked);

        // Constant one: steady-state windows saturate to full scale.
        pcm_q.delete();
        mode = 1;
        repeat (4) window(512);
        check("one_count",       32'(pcm_q.size()), 32'd4);
        check("one_s2",          q_at(2),           32'hFFF);
        check("one_s3",          q_at(3),           32'hFFF);
        $display("one phase: s2=0x%0h s3=0x%0h", q_at(2), q_at(3));

        // Toggle every clk: half scale.
        pcm_q.delete();
        mode = 2;
        repeat (4) window(512);
        check("half_count",      32'(pcm_q.size()), 32'd4);
        check_range("half_s2",   q_at(2), 32'h7F8, 32'h808);
        check_range("half_s3",   q_at(3), 32'h7F8, 32'h808);
        $display("half phase: s2=0x%0h s3=0x%0h", q_at(2), q_at(3));

        // Backpressure: duty windows give distinguishable samples.
        mode = 3;
        duty_n = 32;  window(512);
        duty_n = 64;  window(512);
        bus.pcm_ready = 1'b0;
        duty_n = 128; window(512);
        check("bp_valid",        32'(bus.pcm_valid), 32'h1);
        check("bp_head",         32'(bus.pcm),       32'h200);
        duty_n = 192; window(512);
        duty_n = 256; window(512);
        duty_n = 320; window(512);
        check("bp_no_ovf_at_4",  32'(overflow),      32'h0);
        duty_n = 384; window(512);
        check("bp_ovf_at_5",     32'(overflow),      32'h1);
        duty_n = 448; window(512);
        check("bp_ovf_sticky",   32'(overflow),      32'h1);
        check("bp_head_held",    32'(bus.pcm),       32'h200);
        check("bp_valid_held",   32'(bus.pcm_valid), 32'h1);
        clear_ovf = 1'b1;
        step(1'b0, 1000);
        clear_ovf = 1'b0;
        check("clear_ovf",       32'(overflow),      32'h0);
        check("clear_head_held", 32'(bus.pcm),       32'h200);
        pcm_q.delete();
        bus.pcm_ready = 1'b1;
        repeat (6) step(1'b0, 1000);
        check("drain_count",     32'(pcm_q.size()), 32'd4);
        check("drain_s0",        q_at(0),           32'h200);
        check("drain_s1",        q_at(1),           32'h400);
        check("drain_s2",        q_at(2),           32'h600);
        check("drain_s3",        q_at(3),           32'h800);
        check("drain_empty",     32'(bus.pcm_valid), 32'h0);
        check("drain_unlocked",  32'(locked),       32'h0);
        $display("drain: %0d samples, head 0x%0h", pcm_q.size(), q_at(0));

        // Short window drops lock and its sample; next full window relocks.
        mode = 0;
        pcm_q.delete();
        window(512);
        window(512);
        window(300);
        check("short_pre_locked", 32'(locked),      32'h1);
        window(512);
        check("short_unlocked",  32'(locked),       32'h0);
        check("short_no_push",   32'(pcm_q.size()), 32'd2);
        window(512);
        check("short_relocked",  32'(locked),       32'h1);
        check("short_push_after", 32'(pcm_q.size()), 32'd3);
        $display("short window: samples=%0d locked=%0b", pcm_q.size(), locked);

        // Stopped sample_clock: lock held up to the window end, then lost.
        mode = 1;
        step(1'b0, 1000);
        check("stop_still_locked", 32'(locked),     32'h1);
        repeat (3) step(1'b0, 1000);
        check("stop_unlocked",   32'(locked),       32'h0);
        pcm_q.delete();
        window(512);
        check("stop_seek_no_push", 32'(pcm_q.size()), 32'd0);
        check("stop_seek_unlocked", 32'(locked),    32'h0);
        bus.pcm_ready = 1'b0;
        window(200);
        check("relock_valid",    32'(bus.pcm_valid), 32'h1);
        check("relock_pcm",      32'(bus.pcm),       32'hFFF);
        check("relock_locked",   32'(locked),        32'h1);

        // Asynchronous reset mid-window.
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_pcm",      32'(bus.pcm),       32'h0);
        check("areset_valid",    32'(bus.pcm_valid), 32'h0);
        check("areset_locked",   32'(locked),        32'h0);
        check("areset_overflow", 32'(overflow),      32'h0);
        $display("async reset: pcm=0x%0h valid=%0b locked=%0b", bus.pcm, bus.pcm_valid, locked);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdm_capture.md
# pdm_capture

Receive-side counterpart of the audio DAC path. It takes a 1-bit PWM/PDM stream, either looped back from the `pwmout` pin or from an external modulator, and recovers BITDEPTH-bit PCM samples. It counts high cycles over one sample period, framed by `sample_clock`, then buffers the results in a small FIFO with a valid/ready handshake. It sits beside the DAC in the audio block and serves loopback self-test and line-in capture.

## Interface
- BITDEPTH, 12, width of output PCM word.
- DECIM_LOG2, 9, log2 of clk cycles per sample window; 512 matches the existing clk/512 sample_clock.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_clock  in  1  framing strobe, same clk domain; each rising edge closes one window and opens the next.
- pdm_in  in  1  asynchronous 1-bit stream.
- pcm  out  BITDEPTH  FIFO head sample; reset 0.
- pcm_valid  out  1  FIFO non-empty; reset 0.
- pcm_ready  in  1  consumer accepts the head sample when `pcm_valid` and `pcm_ready` are both high.
- locked  out  1  at least one full-length window has been captured since reset or loss of lock; reset 0.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full; reset 0.
- clear_ovf  in  1  synchronous clear of `overflow`.

## Operation
- Input conditioning
  - `pdm_in` passes through a 2-FF synchronizer to give `bit_s`.
  - `sample_clock` is registered once. `edge` = current high AND previous low.
- State machine, two states. Reset state is SEEK.
  - **SEEK**
    - Ignore `bit_s`.
    - On `edge`: clear `ones` and `wcnt`, go to ACC.
  - **ACC**, every cycle:
    - `ones += bit_s`.
    - `wcnt += 1`.
    - `ones` and `wcnt` are DECIM_LOG2+1 bits wide.
  - **ACC on `edge`, with `wcnt == 2**DECIM_LOG2`**
    - Push the scaled result.
    - Set `locked`.
    - Clear counters; the edge cycle's `bit_s` is counted into the new window.
  - **ACC on `edge`, with `wcnt < 2**DECIM_LOG2` (short window)**
    - Discard the result; no push.
    - Clear `locked`.
    - Restart counters.
  - **ACC with `wcnt` reaching 2**DECIM_LOG2+1 and no `edge` (missing edge)**
    - Clear `locked`.
    - Go to SEEK; no push.
- Scaling, with N = `ones` in [0, W] and W = 2**DECIM_LOG2:
  - If BITDEPTH ≥ DECIM_LOG2: pcm = N << (BITDEPTH−DECIM_LOG2).
  - Otherwise: pcm = N >> (DECIM_LOG2−BITDEPTH).
  - Saturate to 2**BITDEPTH−1; N = W always gives all-ones.
- FIFO
  - Push happens only on a full window.
  - Pop happens on `pcm_valid && pcm_ready`.
  - Full and push with no pop: drop the new sample, set `overflow`. FIFO contents are unchanged.
  - Full, push and pop in the same cycle: both take effect; no overflow.
  - `clear_ovf` clears `overflow`. If set and clear coincide, set wins.
- Reset mid-window discards the partial count.
- `locked` does not gate output; samples already in the FIFO remain poppable after lock is lost.

## Timing
- `pdm_in` to counted: 2 cycles (synchronizer). Window boundaries are defined on `bit_s`.
- `sample_clock` rise to `edge`: 1 cycle.
- `edge` to `pcm_valid` high (empty FIFO): 1 cycle. The push registers on the `edge` cycle.
- `pcm` is stable while `pcm_valid` is high and `pcm_ready` is low.
- After a pop, the next entry (if any) presents in the following cycle; back-to-back pops deliver one sample per cycle.
- First sample after reset: earliest on the second `edge` (SEEK consumes the first).

## Structure
- Shared audio package holds:
  - BITDEPTH default;
  - the SAMPLEFREQ / window-length constant;
  - the capture-state enum (SEEK, ACC).
- Sub-module `sample_fifo`: synchronous FIFO, parameterized width and depth, with `push`, `pop`, `full`, `empty`, `dout`. It is reusable by later audio producers.
- Synchronizer, edge detect, window counter, FSM and scaling live in `pdm_capture`.

## Test plan
- Constant `pdm_in=0`, sample_clock clk/512, `pcm_ready=1`:
  - first pcm arrives after the second edge and equals 0x000;
  - `locked`=1.
- Constant `pdm_in=1`:
  - every pcm = 0xFFF (saturated).
- 50% pattern (toggle each clk):
  - each pcm = 0x800 ± 0x008 (N = 256 ± 1).
- `pcm_ready=0` for 6 windows:
  - 4 samples held with `pcm_valid`=1;
  - `overflow`=1 after the 5th window;
  - FIFO contents are the first 4 samples;
  - `clear_ovf` pulse clears `overflow`.
- One sample_clock period shortened to 300 clks:
  - that window produces no push;
  - `locked` drops, then returns after the next full 512-clk window.
- Stop sample_clock:
  - after 513 clks in ACC, `locked`=0 and the FSM is in SEEK;
  - assert `rst_n` low mid-window: all outputs return to reset values asynchronously.
